stream_demux: RTL and testbench

Registered, flow-controlled 1-to-CHANNELS demultiplexer for the asyncFIFO datapath. Each beat on the single input stream is steered by its select field to one of CHANNELS output streams, and each output has its own DEPTH-entry buffer. A stalled output therefore never blocks beats bound for other outputs once they are buffered. An optional packet-lock mode holds the route for a whole packet.

---
 rtl/stream_demux.sv | 140 ++++++++++++++
 tb/tb_stream_demux.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-CHANNELS stream demultiplexer with a DEPTH-entry buffer per output.
// Defining STREAM_DEMUX_LOCK_EN compiles in packet-lock routing (route held until in_last).
module stream_demux #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned SEL_WIDTH = $clog2(CHANNELS),
  parameter int unsigned DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SEL_WIDTH-1:0] in_sel,
  input  logic                 in_last,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data [0:CHANNELS-1],
  output logic [0:CHANNELS-1]  out_valid,
  input  logic [0:CHANNELS-1]  out_ready,
  output logic                 sel_err
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [SEL_WIDTH-1:0] ch;
  logic                 ch_ok;
  logic                 accept;
  logic [0:CHANNELS-1]  push;
  logic [0:CHANNELS-1]  pop;
  logic [0:CHANNELS-1]  full;
  logic [CntW-1:0]      count_q [CHANNELS];
  logic [PtrW-1:0]      wptr_q  [CHANNELS];
  logic [PtrW-1:0]      rptr_q  [CHANNELS];
  logic [WIDTH-1:0]     mem_q   [CHANNELS][DEPTH];
  logic                 sel_err_q;

`ifdef STREAM_DEMUX_LOCK_EN
  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [SEL_WIDTH-1:0] lock_ch_q, lock_ch_d;

  assign ch = (state_q == StLocked) ? lock_ch_q : in_sel;

  // Only in-range channels can be latched, so LOCKED always routes in range.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    case (state_q)
      StIdle: begin
        if (accept && ch_ok && !in_last) begin
          state_d   = StLocked;
          lock_ch_d = in_sel;
        end
      end
      StLocked: begin
        if (accept && in_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`else
  logic unused_last;

  assign ch          = in_sel;
  assign unused_last = in_last;
`endif

  assign ch_ok  = 32'(ch) < CHANNELS;
  assign accept = in_valid && in_ready;

  // Out-of-range beats are always taken (and dropped) so they cannot wedge the input.
  always_comb begin
    in_ready = 1'b1;
    full     = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      full[c] = (count_q[c] == CntW'(DEPTH));
      if (ch_ok && (32'(ch) == c)) in_ready = !full[c];
    end
  end

  always_comb begin
    out_valid = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      out_valid[c] = (count_q[c] != '0);
      out_data[c]  = mem_q[c][rptr_q[c]];
    end
  end

  always_comb begin
    push = '0;
    pop  = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      push[c] = accept && ch_ok && (32'(ch) == c);
      pop[c]  = out_valid[c] && out_ready[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        count_q[c] <= '0;
        wptr_q[c]  <= '0;
        rptr_q[c]  <= '0;
      end
      sel_err_q <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (push[c]) wptr_q[c] <= wptr_q[c] + PtrW'(1);
        if (pop[c])  rptr_q[c] <= rptr_q[c] + PtrW'(1);
        if (push[c] && !pop[c]) begin
          count_q[c] <= count_q[c] + CntW'(1);
        end else if (pop[c] && !push[c]) begin
          count_q[c] <= count_q[c] - CntW'(1);
        end
      end
      if (accept && !ch_ok) sel_err_q <= 1'b1;
    end
  end

  // Storage needs no reset: contents are only observed while the count says valid.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (push[c]) mem_q[c][wptr_q[c]] <= in_data;
    end
  end

  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux (3 channels, depth 2): directed steps, then random traffic,
// all compared against a queue-based reference model.
module tb_stream_demux;
  localparam int NCH   = 3;
  localparam int DEPTH = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     in_data;
  logic [1:0]     in_sel;
  logic           in_last;
  logic           in_valid;
  logic           in_ready;
  logic [7:0]     out_data [0:NCH-1];
  logic [0:NCH-1] out_valid;
  logic [0:NCH-1] out_ready;
  logic           sel_err;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  logic [7:0] mq [NCH][$];
  bit         m_err;
  bit         m_locked;
  int         m_lock_ch;

  stream_demux #(
    .WIDTH    (8),
    .CHANNELS (NCH),
    .SEL_WIDTH(2),
    .DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_last  (in_last),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sel_err  (sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_ch();
    return m_locked ? m_lock_ch : int'(in_sel);
  endfunction

  function automatic logic exp_ready();
    int ch;
    ch = eff_ch();
    if (ch >= NCH) return 1'b1;
    return mq[ch].size() < DEPTH;
  endfunction

  task automatic check_all();
    chk("in_ready", in_ready, exp_ready());
    chk("sel_err", sel_err, m_err);
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("out_valid%0d", c), out_valid[c], mq[c].size() > 0);
      if (mq[c].size() > 0) chk($sformatf("out_data%0d", c), out_data[c], mq[c][0]);
    end
  endtask

  task automatic model_update();
    int   ch;
    logic acc;
    ch  = eff_ch();
    acc = in_valid && exp_ready();
    if (rst) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      m_err    = 1'b0;
      m_locked = 1'b0;
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      if (mq[c].size() > 0 && out_ready[c]) void'(mq[c].pop_front());
    end
    if (acc) begin
      if (ch >= NCH) m_err = 1'b1;
      else mq[ch].push_back(in_data);
    end
`ifdef STREAM_DEMUX_LOCK_EN
    if (!m_locked) begin
      if (acc && ch < NCH && !in_last) begin
        m_locked  = 1'b1;
        m_lock_ch = ch;
      end
    end else if (acc && in_last) begin
      m_locked = 1'b0;
    end
`endif
  endtask

  // Check before the edge, advance the model at the edge, leave inputs free to change at +1.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic l);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    in_last  = l;
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = '1;
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    m_err     = 1'b0;
    m_locked  = 1'b0;
    m_lock_ch = 0;
    @(posedge clk);
    model_update();
    #1;
    cycle();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sel_err", sel_err, 0);

    // Basic steering
    rst = 1'b0;
    drive(1'b1, 2'd0, 8'hA1, 1'b1);
    cycle();
    chk("tp1_v0", out_valid[0], 1);
    chk("tp1_d0", out_data[0], 8'hA1);
    chk("tp1_v2_lo", out_valid[2], 0);
    drive(1'b1, 2'd2, 8'hB2, 1'b1);
    cycle();
    chk("tp1_v2", out_valid[2], 1);
    chk("tp1_d2", out_data[2], 8'hB2);
    chk("tp1_v0_pop", out_valid[0], 0);
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    cycle();

    // Backpressure on ch1, other channels keep flowing
    out_ready[1] = 1'b0;
    drive(1'b1, 2'd1, 8'h11, 1'b1);
    cycle();
    drive(1'b1, 2'd1, 8'h22, 1'b1);
    cycle();
    drive(1'b1, 2'd1, 8'h33, 1'b1);
    #1;
    chk("full_ready", in_ready, 0);
    drive(1'b1, 2'd2, 8'h44, 1'b1);
    #1;
    chk("bypass_ready", in_ready, 1);
    cycle();
    chk("bypass_v2", out_valid[2], 1);
    chk("bypass_d2", out_data[2], 8'h44);
    drive(1'b1, 2'd1, 8'h33, 1'b1);
    out_ready[1] = 1'b1;
    #1;
    chk("full_pop_ready", in_ready, 0);
    cycle();
    chk("after_pop_ready", in_ready, 1);
    chk("order_d1a", out_data[1], 8'h22);
    cycle();
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    chk("order_d1b", out_data[1], 8'h33);
    cycle();
    chk("drain_v1", out_valid[1], 0);

    // Out-of-range select
    drive(1'b1, 2'd3, 8'h5A, 1'b1);
    #1;
    chk("oor_ready", in_ready, 1);
    cycle();
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    chk("oor_err", sel_err, 1);
    chk("oor_no_valid", out_valid, 0);
    repeat (3) cycle();
    chk("oor_err_held", sel_err, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("oor_err_clr", sel_err, 0);

`ifdef STREAM_DEMUX_LOCK_EN
    drive(1'b1, 2'd2, 8'hC0, 1'b0);
    cycle();
    chk("lock_v2a", out_valid[2], 1);
    chk("lock_d2a", out_data[2], 8'hC0);
    drive(1'b1, 2'd0, 8'hC1, 1'b0);
    cycle();
    chk("lock_d2b", out_data[2], 8'hC1);
    chk("lock_v0", out_valid[0], 0);
    drive(1'b1, 2'd1, 8'hC2, 1'b1);
    cycle();
    chk("lock_d2c", out_data[2], 8'hC2);
    chk("lock_v1", out_valid[1], 0);
    drive(1'b1, 2'd0, 8'hC3, 1'b1);
    cycle();
    chk("unlock_v0", out_valid[0], 1);
    chk("unlock_d0", out_data[0], 8'hC3);
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    cycle();
`endif

    // Reset mid-operation with ch0 holding two beats (and, when compiled in, a held lock)
    out_ready[0] = 1'b0;
    drive(1'b1, 2'd0, 8'hD1, 1'b0);
    cycle();
    drive(1'b1, 2'd0, 8'hD2, 1'b0);
    cycle();
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    chk("mid_v0", out_valid[0], 1);
    rst = 1'b1;
    cycle();
    chk("mid_rst_v0", out_valid[0], 0);
    chk("mid_rst_err", sel_err, 0);
    rst          = 1'b0;
    out_ready[0] = 1'b1;
    drive(1'b1, 2'd2, 8'hE3, 1'b1);
    cycle();
    chk("post_rst_v2", out_valid[2], 1);
    chk("post_rst_d2", out_data[2], 8'hE3);
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    cycle();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_sel   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      in_data  = 8'($urandom);
      in_last  = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < NCH; c++) out_ready[c] = ($urandom_range(0, 9) < 6);
      rst = ($urandom_range(0, 79) == 0);
      cycle();
    end
    rst = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    out_ready = '1;
    repeat (4) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
